pia_irq_channel: RTL and testbench



---
 rtl/pia_irq_channel.sv | 76 +++++++
 tb/tb_pia_irq_channel.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pia_irq_channel.sv
// pia_irq_channel: one PIA side's Cx1/Cx2 edge detection, IRQx1/IRQx2 flags, read-clear lock and Cx2 output sequencing
//   in : clk, nreset (async active-low), cr[5:0], readp (data register read), deselect (end of access), cx1, cx2_in
//   out: irq1/irq2 (CR bits 7/6), nirq (active-low request), cx2_out, cx2_oe
module pia_irq_channel #(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [5:0] cr,
  input  logic       readp,
  input  logic       deselect,
  input  logic       cx1,
  input  logic       cx2_in,
  output logic       irq1,
  output logic       irq2,
  output logic       nirq,
  output logic       cx2_out,
  output logic       cx2_oe
);
  typedef enum logic {READY, LOCKED} lock_t;
  typedef enum logic [1:0] {IDLE, HS_LOW, PULSE} cx2_t;
  logic [SYNC_STAGES-1:0] s1, s2;
  logic                   p1, p2, armed, act1, act2, clr, hs, pm, nxt_out;
  logic [2:0]             arm;
  logic [3:0]             pcnt, nxt_pcnt;
  lock_t                  lock;
  cx2_t                   st, nxt_st;
  logic                   unused_cr2;
  assign unused_cr2 = cr[2];
  // pins already high at reset release would look like rising edges until the chain and previous sample fill
  assign armed = arm == 3'(SYNC_STAGES + 1);
  assign act1  = armed & (s1[SYNC_STAGES-1] ^ p1) & (cr[1] ? s1[SYNC_STAGES-1] : ~s1[SYNC_STAGES-1]);
  assign act2  = armed & ~cr[5] & (s2[SYNC_STAGES-1] ^ p2) & (cr[4] ? s2[SYNC_STAGES-1] : ~s2[SYNC_STAGES-1]);
  assign clr   = lock == READY & readp;
  assign nirq  = ~((irq1 & cr[0]) | (irq2 & cr[3] & ~cr[5]));
  assign cx2_oe = cr[5];
  assign hs = cr[5:3] == 3'b100;
  assign pm = cr[5:3] == 3'b101;
  // leaving a mode is implicit: HS_LOW/PULSE are only held while their own mode is selected
  always_comb begin
    nxt_st   = hs ? ((clr || (st == HS_LOW && !act1)) ? HS_LOW : IDLE)
             : pm ? ((clr || (st == PULSE && pcnt != 4'd0)) ? PULSE : IDLE)
             : IDLE;
    nxt_pcnt = (pm && clr) ? 4'(PULSE_CYCLES - 1) : (pm && st == PULSE && pcnt != 4'd0) ? pcnt - 4'd1 : 4'd0;
    nxt_out  = !cr[5] ? 1'b1 : cr[4] ? cr[3] : nxt_st == IDLE;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1      <= '0;
      s2      <= '0;
      p1      <= 1'b0;
      p2      <= 1'b0;
      arm     <= 3'd0;
      lock    <= READY;
      irq1    <= 1'b0;
      irq2    <= 1'b0;
      st      <= IDLE;
      pcnt    <= 4'd0;
      cx2_out <= 1'b1;
    end else begin
      s1      <= {s1[SYNC_STAGES-2:0], cx1};
      s2      <= {s2[SYNC_STAGES-2:0], cx2_in};
      p1      <= s1[SYNC_STAGES-1];
      p2      <= s2[SYNC_STAGES-1];
      arm     <= armed ? arm : arm + 3'd1;
      lock    <= lock == READY ? (readp ? LOCKED : READY) : (deselect ? READY : LOCKED);
      // an edge in the same cycle as a clear leaves its flag set
      irq1    <= act1 | (irq1 & ~clr);
      irq2    <= ~cr[5] & (act2 | (irq2 & ~clr));
      st      <= nxt_st;
      pcnt    <= nxt_pcnt;
      cx2_out <= nxt_out;
    end
  end
endmodule

// File: tb/tb_pia_irq_channel.sv
// tb_pia_irq_channel: directed self-checking bench for pia_irq_channel
module tb_pia_irq_channel;
  logic       clk = 1'b0, nreset = 1'b0;
  logic [5:0] cr = 6'b000011;
  logic       readp = 1'b0, deselect = 1'b0, cx1 = 1'b1, cx2_in = 1'b1;
  logic       irq1, irq2, nirq, cx2_out, cx2_oe;
  int         n_tests = 0, n_fail = 0;
  pia_irq_channel #(.SYNC_STAGES(2), .PULSE_CYCLES(3)) dut (
    .clk(clk), .nreset(nreset), .cr(cr), .readp(readp), .deselect(deselect),
    .cx1(cx1), .cx2_in(cx2_in), .irq1(irq1), .irq2(irq2), .nirq(nirq),
    .cx2_out(cx2_out), .cx2_oe(cx2_oe)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic desel;
    deselect = 1'b1;
    step(1);
    deselect = 1'b0;
  endtask
  initial begin
    step(3);
    chk("rst_irq1", irq1, 1'b0);
    chk("rst_irq2", irq2, 1'b0);
    chk("rst_nirq", nirq, 1'b1);
    chk("rst_cx2_out", cx2_out, 1'b1);
    chk("rst_cx2_oe", cx2_oe, 1'b0);
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("arm_irq1", irq1, 1'b0);
      chk("arm_nirq", nirq, 1'b1);
    end
    cx1 = 1'b0;
    step(5);
    chk("fall_inactive", irq1, 1'b0);
    cx1 = 1'b1;
    step(2);
    chk("lat_early", irq1, 1'b0);
    step(1);
    chk("lat_irq1", irq1, 1'b1);
    chk("lat_nirq", nirq, 1'b0);
    readp = 1'b1;
    step(1);
    chk("rd_clear", irq1, 1'b0);
    chk("rd_nirq", nirq, 1'b1);
    cx1 = 1'b0;
    step(3);
    cx1 = 1'b1;
    step(3);
    chk("locked_set", irq1, 1'b1);
    step(1);
    chk("locked_hold", irq1, 1'b1);
    readp = 1'b0;
    desel();
    chk("desel_noclr", irq1, 1'b1);
    readp = 1'b1;
    step(1);
    chk("rd2_clear", irq1, 1'b0);
    readp = 1'b0;
    desel();
    cr = 6'b000010;
    cx1 = 1'b0;
    step(3);
    cx1 = 1'b1;
    step(3);
    chk("dis_irq1", irq1, 1'b1);
    chk("dis_nirq", nirq, 1'b1);
    cr = 6'b000011;
    #1;
    chk("en_nirq", nirq, 1'b0);
    readp = 1'b1;
    step(1);
    readp = 1'b0;
    desel();
    chk("en_cleared", irq1, 1'b0);
    cr = 6'b100000;
    step(1);
    chk("hs_idle", cx2_out, 1'b1);
    chk("hs_oe", cx2_oe, 1'b1);
    readp = 1'b1;
    step(1);
    readp = 1'b0;
    chk("hs_low", cx2_out, 1'b0);
    desel();
    cx1 = 1'b0;
    step(2);
    chk("hs_wait", cx2_out, 1'b0);
    step(1);
    chk("hs_release", cx2_out, 1'b1);
    chk("hs_irq1", irq1, 1'b1);
    cx1 = 1'b1;
    step(4);
    chk("hs_rise_ign", cx2_out, 1'b1);
    cx1 = 1'b0;
    step(2);
    readp = 1'b1;
    step(1);
    readp = 1'b0;
    chk("hs_tie_low", cx2_out, 1'b0);
    chk("hs_tie_irq1", irq1, 1'b1);
    step(1);
    chk("hs_tie_hold", cx2_out, 1'b0);
    desel();
    cr = 6'b101000;
    step(1);
    chk("pm_idle", cx2_out, 1'b1);
    readp = 1'b1;
    step(1);
    readp = 1'b0;
    chk("pm_low1", cx2_out, 1'b0);
    step(1);
    chk("pm_low2", cx2_out, 1'b0);
    step(1);
    chk("pm_low3", cx2_out, 1'b0);
    step(1);
    chk("pm_end", cx2_out, 1'b1);
    desel();
    cr = 6'b111000;
    step(1);
    chk("man_hi", cx2_out, 1'b1);
    cr = 6'b110000;
    #1;
    chk("man_lat", cx2_out, 1'b1);
    step(1);
    chk("man_lo", cx2_out, 1'b0);
    chk("man_oe", cx2_oe, 1'b1);
    cr = 6'b001000;
    step(2);
    chk("c2_in_out", cx2_out, 1'b1);
    chk("c2_in_oe", cx2_oe, 1'b0);
    cx2_in = 1'b0;
    step(2);
    readp = 1'b1;
    step(1);
    readp = 1'b0;
    chk("c2_tie_irq2", irq2, 1'b1);
    chk("c2_tie_nirq", nirq, 1'b0);
    desel();
    cr = 6'b101000;
    #1;
    chk("c2_out_nirq", nirq, 1'b1);
    step(1);
    chk("c2_forced", irq2, 1'b0);
    cr = 6'b110000;
    step(1);
    chk("pre_rst_lo", cx2_out, 1'b0);
    nreset = 1'b0;
    #1;
    chk("async_rst_out", cx2_out, 1'b1);
    chk("async_rst_irq2", irq2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
